avalon_mem_arbiter: RTL and testbench
=====================================

Name: avalon_mem_arbiter

Overview:
- Parametrised Avalon-MM master that replaces the CPU's ad-hoc shared read/write/address muxing.
- Two requester channels, instruction fetch and data load/store, are arbitrated onto one bus.
- Generates byteenable and lane-shifts write data for byte/half/word/full accesses; extracts and sign/zero-extends read data.
- Detects misalignment; aborts stalled transfers after a programmable timeout.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, bus data width; power of two, at least 32. BE_W = DATA_W/8 and LB = log2(BE_W) are derived.
- FETCH_PRIO, 0. 0 = data channel wins simultaneous requests; 1 = fetch channel wins.
- TIMEOUT, 0. Maximum consecutive waitrequest cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch request, level, held until f_ack
- f_addr  in  ADDR_W  fetch byte address; low LB bits ignored (forced aligned)
- f_ack  out  1  one-cycle pulse; f_rdata/f_err valid
- f_rdata  out  DATA_W  fetched word (raw readdata)
- f_err  out  1  fetch aborted by timeout
- d_req  in  1  data request, level, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = full DATA_W
- d_signed  in  1  sign-extend load result
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data, right-justified
- d_ack  out  1  one-cycle pulse; d_rdata/d_err valid
- d_rdata  out  DATA_W  extended load result (0 for stores)
- d_err  out  1  misaligned access or timeout
- address  out  ADDR_W  Avalon address, lane-aligned (low LB bits 0)
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  DATA_W  lane-shifted store data
- byteenable  out  BE_W  active lanes
- waitrequest  in  1  slave stall
- readdata  in  DATA_W  sampled on the edge where read=1 and waitrequest=0
- busy  out  1  state is not IDLE

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; timeout counter 0.
  - A reset mid-transfer drops read/write on the next cycle; no ack is issued for the killed transfer.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Samples f_req/d_req.
  - If both are high, FETCH_PRIO selects the winner; the loser stays pending.
  - The winner's request fields are latched and the FSM moves to BUS.
  - A misaligned data request skips BUS and goes directly to RESP with d_err=1. Misaligned means: half with lane[0] set; word with lane[1:0] non-zero; full with lane non-zero; size 2 with DATA_W=32 behaves as size 3.
- BUS:
  - Drives read or write continuously with address, byteenable and writedata all from latched values, stable while waitrequest=1.
  - Transfer completes on the edge where waitrequest=0: readdata is captured and the FSM goes to RESP.
  - If TIMEOUT>0 and waitrequest has been high for TIMEOUT consecutive BUS cycles, read/write drop and the FSM goes to RESP with err=1.
- RESP: pulses f_ack or d_ack for exactly one cycle, then IDLE. The requester deasserts or changes its request after seeing ack.
- Latency: request seen in IDLE at cycle N → bus command at N+1 → ack at N+2 with zero wait states; each wait state adds one cycle.
- Lane encoding (lane = addr[LB-1:0]):
  - byteenable = byte 1<<lane; half 3<<lane; word 0xF<<lane; full all ones.
  - writedata = d_wdata << 8*lane, with unused bits 0.
- Loads:
  - d_rdata = (readdata >> 8*lane) truncated to size, then sign-extended if d_signed else zero-extended to DATA_W.
  - Fetch returns raw readdata.
- Fetch path: byteenable is all ones.
- Fairness: after a contested grant, the other channel wins the next contested IDLE decision (alternates). This prevents fetch starvation during load streams.
- Write and read are never asserted together; at most one transfer is outstanding.

Test Plan:
- Word load, zero wait: d_addr=0x100, readdata=0xDEADBEEF → read at N+1 with byteenable=0xF; d_ack at N+2 with d_rdata=0xDEADBEEF, d_err=0.
- Signed byte load: d_addr=0x103, size 0, d_signed=1, readdata=0x80FF0000 → byteenable=0x8; d_rdata=0xFFFFFF80. With d_signed=0 → d_rdata=0x00000080.
- Half store: d_addr=0x202, d_wdata=0x1234 → writedata=0x12340000, byteenable=0xC, write held through 3 waitrequest cycles; d_ack 1 cycle after waitrequest falls.
- Misaligned: word load at 0x101 → no read/write asserted; d_ack with d_err=1 at N+1.
- Contention: f_req and d_req high together, FETCH_PRIO=0 → data served first, fetch next, then alternation on repeated contention.
- Timeout: TIMEOUT=4 with waitrequest stuck high → read drops after 4 cycles; f_ack with f_err=1. Reset mid-BUS → read=0 next cycle, no ack.

Source files
------------

// File: rtl/avalon_mem_arbiter_if.sv
// Avalon-MM bus bundle between the arbiter (master) and a memory slave.
//
// Handshake: the master holds read or write, together with address,
// byteenable and writedata, steady while waitrequest is high; the transfer
// completes on the rising edge where read/write is high and waitrequest is
// low, and readdata is sampled on that same edge.
interface avalon_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Two-channel (instruction fetch / data load-store) Avalon-MM master.
// Arbitrates requests with alternating priority on contention, builds
// byteenable and lane-shifted write data, extracts and extends load data,
// rejects misaligned data accesses and aborts transfers stalled longer
// than TIMEOUT wait cycles. FSM state is observable through busy.
module avalon_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FETCH_PRIO = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 f_req,
  input  logic [ADDR_W-1:0]    f_addr,
  output logic                 f_ack,
  output logic [DATA_W-1:0]    f_rdata,
  output logic                 f_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [1:0]           d_size,
  input  logic                 d_signed,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  output logic                 d_ack,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_err,
  avalon_mem_arbiter_if.master bus,
  output logic                 busy
);
  localparam int BE_W = DATA_W / 8;
  localparam int LB   = $clog2(BE_W);
  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;

  // Contention priority toggles after every contested grant.
  logic          fetch_first;
  logic          lat_fetch;
  logic          lat_we;
  logic          lat_signed;
  logic [1:0]    lat_size;
  logic [LB-1:0] lat_lane;
  logic [CW-1:0] wait_cnt;

  logic [ADDR_W-1:0] address_q;
  logic              read_q;
  logic              write_q;
  logic [DATA_W-1:0] writedata_q;
  logic [BE_W-1:0]   byteenable_q;

  logic              grant_f;
  logic              grant_d;
  logic [1:0]        d_esize;
  logic [LB-1:0]     d_lane;
  logic              d_misaligned;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_wmask;
  logic [DATA_W-1:0] d_wshift;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] ld_ext;

  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = byteenable_q;
  assign busy           = (state != IDLE);

  // Grant selection and data-request decode (lanes, alignment, store data).
  always_comb begin
    grant_f      = f_req && (!d_req || fetch_first);
    grant_d      = d_req && !grant_f;
    d_lane       = d_addr[LB-1:0];
    // A 32-bit word on a 32-bit bus is simply a full-width access.
    d_esize      = (d_size == 2'd2 && DATA_W == 32) ? 2'd3 : d_size;
    d_misaligned = 1'b0;
    d_be         = '1;
    d_wmask      = '1;
    case (d_esize)
      2'd0: begin
        d_be    = BE_W'(1) << d_lane;
        d_wmask = DATA_W'(8'hFF);
      end
      2'd1: begin
        d_misaligned = d_lane[0];
        d_be         = BE_W'(3) << d_lane;
        d_wmask      = DATA_W'(16'hFFFF);
      end
      2'd2: begin
        d_misaligned = (d_lane[1:0] != 2'd0);
        d_be         = BE_W'(15) << d_lane;
        d_wmask      = DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        d_misaligned = (d_lane != '0);
      end
    endcase
    d_wshift = (d_wdata & d_wmask) << {d_lane, 3'b000};
  end

  // Load-data extraction: right-justify the addressed lanes, then extend.
  always_comb begin
    rd_shift = bus.readdata >> {lat_lane, 3'b000};
    case (lat_size)
      2'd0:    ld_ext = lat_signed ? DATA_W'($signed(rd_shift[7:0]))
                                   : DATA_W'(rd_shift[7:0]);
      2'd1:    ld_ext = lat_signed ? DATA_W'($signed(rd_shift[15:0]))
                                   : DATA_W'(rd_shift[15:0]);
      2'd2:    ld_ext = lat_signed ? DATA_W'($signed(rd_shift[31:0]))
                                   : DATA_W'(rd_shift[31:0]);
      default: ld_ext = rd_shift;
    endcase
  end

  // Arbitration, bus sequencing and one-cycle response generation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fetch_first  <= (FETCH_PRIO != 0);
      lat_fetch    <= 1'b0;
      lat_we       <= 1'b0;
      lat_signed   <= 1'b0;
      lat_size     <= 2'd0;
      lat_lane     <= '0;
      wait_cnt     <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      f_ack        <= 1'b0;
      f_rdata      <= '0;
      f_err        <= 1'b0;
      d_ack        <= 1'b0;
      d_rdata      <= '0;
      d_err        <= 1'b0;
    end else begin
      f_ack <= 1'b0;
      d_ack <= 1'b0;
      f_err <= 1'b0;
      d_err <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (f_req || d_req) begin
            if (f_req && d_req) fetch_first <= !grant_f;
            lat_fetch    <= grant_f;
            lat_we       <= grant_d && d_we;
            lat_signed   <= d_signed;
            lat_size     <= grant_f ? 2'd3 : d_esize;
            lat_lane     <= grant_f ? '0 : d_lane;
            address_q    <= (grant_f ? f_addr : d_addr) & ~ADDR_W'(BE_W - 1);
            byteenable_q <= grant_f ? '1 : d_be;
            writedata_q  <= (grant_d && d_we) ? d_wshift : '0;
            if (grant_d && d_misaligned) begin
              // Never reaches the bus; answered straight away with an error.
              state   <= RESP;
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end else begin
              state   <= BUS;
              read_q  <= !(grant_d && d_we);
              write_q <= grant_d && d_we;
            end
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state   <= RESP;
            if (lat_fetch) begin
              f_ack   <= 1'b1;
              f_rdata <= bus.readdata;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= lat_we ? '0 : ld_ext;
            end
          end else if (TIMEOUT > 0 && int'(wait_cnt) == TIMEOUT - 1) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            state   <= RESP;
            if (lat_fetch) begin
              f_ack   <= 1'b1;
              f_err   <= 1'b1;
              f_rdata <= '0;
            end else begin
              d_ack   <= 1'b1;
              d_err   <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter (32-bit bus, data priority first, TIMEOUT=4).
// A transaction-level model predicts every output each cycle from the
// request/bus inputs; directed sequences pin the model with literal values,
// then a randomized run exercises contention, wait states, misalignment,
// timeouts and back-to-back requests.
module tb_avalon_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int FETCH_PRIO = 0;
  localparam int TIMEOUT    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_signed;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];

  avalon_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  avalon_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FETCH_PRIO(FETCH_PRIO), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .bus(bus), .busy(busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_phase = 0;       // 0 accepting requests, 1 transfer on bus, 2 acknowledging
  bit          m_fetch_turn = 1'b0;
  int          m_waits = 0;
  bit          t_fetch, t_we, t_signed;
  int          t_n, t_lane;
  logic [31:0] t_addr, t_wdata;

  logic        e_read = 0, e_write = 0, e_busy = 0;
  logic        e_f_ack = 0, e_d_ack = 0, e_f_err = 0, e_d_err = 0;
  logic [31:0] e_addr = 0, e_wd = 0, e_f_rdata = 0, e_d_rdata = 0;
  logic [3:0]  e_be = 0;

  function automatic logic [3:0] lane_be(int lane, int n);
    logic [3:0] be;
    be = '0;
    for (int i = 0; i < 4; i++) if (i >= lane && i < lane + n) be[i] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] place(logic [31:0] wd, int lane, int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*(lane+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] extract(logic [31:0] rd, int lane, int n, bit sgn);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = rd[8*(lane+i) +: 8];
    if (sgn && n < 4 && r[8*n-1]) for (int i = 8*n; i < 32; i++) r[i] = 1'b1;
    return r;
  endfunction

  task automatic model_finish(bit err);
    e_read  = 1'b0;
    e_write = 1'b0;
    m_phase = 2;
    if (t_fetch) begin
      e_f_ack = 1'b1; e_f_err = err; e_f_rdata = bus.readdata;
    end else begin
      e_d_ack = 1'b1; e_d_err = err;
      e_d_rdata = (err || t_we) ? 32'h0 : extract(bus.readdata, t_lane, t_n, t_signed);
    end
  endtask

  // Predicts outputs after the coming rising edge from the inputs now applied.
  task automatic model_edge();
    e_f_ack = 0; e_d_ack = 0; e_f_err = 0; e_d_err = 0;
    if (reset) begin
      m_phase = 0; m_fetch_turn = (FETCH_PRIO != 0);
      e_read = 0; e_write = 0; e_addr = 0; e_be = 0; e_wd = 0;
      e_f_rdata = 0; e_d_rdata = 0;
    end else begin
      case (m_phase)
        0: if (f_req || d_req) begin
          if (f_req && d_req) begin
            t_fetch = m_fetch_turn;
            m_fetch_turn = !t_fetch;
          end else begin
            t_fetch = f_req;
          end
          if (t_fetch) begin
            t_we = 0; t_n = 4; t_lane = 0; t_addr = f_addr; t_wdata = 0; t_signed = 0;
          end else begin
            t_we = d_we; t_n = (d_size >= 2) ? 4 : (1 << d_size);
            t_lane = int'(d_addr % 4); t_addr = d_addr; t_wdata = d_wdata; t_signed = d_signed;
          end
          if (t_lane % t_n != 0) begin
            e_d_ack = 1; e_d_err = 1; e_d_rdata = 0; m_phase = 2;
          end else begin
            m_phase = 1; m_waits = 0;
            e_read = !t_we; e_write = t_we;
            e_addr = t_addr & ~32'h3;
            e_be   = lane_be(t_lane, t_n);
            e_wd   = t_we ? place(t_wdata, t_lane, t_n) : 32'h0;
          end
        end
        1: begin
          if (!bus.waitrequest) model_finish(1'b0);
          else begin
            m_waits++;
            if (m_waits == TIMEOUT) model_finish(1'b1);
          end
        end
        default: m_phase = 0;
      endcase
    end
    e_busy = (m_phase != 0);
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    chk("read", bus.read, e_read);
    chk("write", bus.write, e_write);
    chk("busy", busy, e_busy);
    chk("f_ack", f_ack, e_f_ack);
    chk("d_ack", d_ack, e_d_ack);
    chk("rw_excl", bus.read & bus.write, 32'h0);
    if (e_read || e_write) begin
      chk("address", bus.address, e_addr);
      chk("byteenable", bus.byteenable, e_be);
    end
    if (e_write) chk("writedata", bus.writedata, e_wd);
    if (e_f_ack) begin
      chk("f_err", f_err, e_f_err);
      if (!e_f_err) chk("f_rdata", f_rdata, e_f_rdata);
    end
    if (e_d_ack) begin
      chk("d_err", d_err, e_d_err);
      if (!e_d_err) chk("d_rdata", d_rdata, e_d_rdata);
    end
  endtask

  // One clock: predict, let the edge happen, compare on the falling edge.
  task automatic tick();
    model_edge();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  // ---------------- drivers ----------------
  task automatic set_d(bit we, logic [1:0] size, bit sgn, logic [31:0] addr, logic [31:0] wd);
    d_req = 1; d_we = we; d_size = size; d_signed = sgn; d_addr = addr; d_wdata = wd;
  endtask

  task automatic new_fetch();
    f_req = 1; f_addr = $urandom();
  endtask

  task automatic new_data();
    set_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom(), $urandom());
    if ($urandom_range(0, 1) == 1) d_addr[1:0] = 2'b00;
  endtask

  // Stimulus: directed sequences, then randomized traffic, then the report.
  initial begin
    reset = 1; f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_signed = 0;
    d_addr = 0; d_wdata = 0; bus.waitrequest = 0; bus.readdata = 0;
    repeat (3) tick();
    chk("rst_read", bus.read, 0);
    chk("rst_busy", busy, 0);
    chk("rst_be", bus.byteenable, 0);
    reset = 0;
    tick();

    // Word load, zero wait states.
    bus.readdata = 32'hDEADBEEF;
    set_d(0, 2, 0, 32'h100, 0);
    tick(); chk("wl_read", bus.read, 1); chk("wl_be", bus.byteenable, 4'hF);
    chk("wl_addr", bus.address, 32'h100);
    tick(); chk("wl_ack", d_ack, 1); chk("wl_rdata", d_rdata, 32'hDEADBEEF); chk("wl_err", d_err, 0);
    d_req = 0; tick();

    // Signed then unsigned byte load from lane 3.
    bus.readdata = 32'h80FF0000;
    set_d(0, 0, 1, 32'h103, 0);
    tick(); chk("sb_be", bus.byteenable, 4'h8);
    tick(); chk("sb_ack", d_ack, 1); chk("sb_rdata", d_rdata, 32'hFFFFFF80);
    d_signed = 0;
    tick(); tick();
    tick(); chk("ub_ack", d_ack, 1); chk("ub_rdata", d_rdata, 32'h00000080);
    d_req = 0; tick();

    // Half store held through three wait states.
    bus.waitrequest = 1;
    set_d(1, 1, 0, 32'h202, 32'h1234);
    tick(); chk("hs_write", bus.write, 1); chk("hs_wd", bus.writedata, 32'h12340000);
    chk("hs_be", bus.byteenable, 4'hC);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("hs_hold", bus.write, 1); chk("hs_noack", d_ack, 0);
    end
    bus.waitrequest = 0;
    tick(); chk("hs_ack", d_ack, 1); chk("hs_drop", bus.write, 0); chk("hs_rdata", d_rdata, 0);
    d_req = 0; tick();

    // Misaligned word load never reaches the bus.
    set_d(0, 2, 0, 32'h101, 0);
    tick(); chk("ma_ack", d_ack, 1); chk("ma_err", d_err, 1); chk("ma_read", bus.read, 0);
    d_req = 0; tick();

    // Contention and alternation; expected grant order queued up front.
    exp_q.push_back(32'h2000); exp_q.push_back(32'h1000); exp_q.push_back(32'h1004);
    exp_q.push_back(32'h2004); exp_q.push_back(32'h2008); exp_q.push_back(32'h1008);
    f_req = 1; f_addr = 32'h1000; set_d(0, 2, 0, 32'h2000, 0);
    tick(); chk("grant_order", bus.address, exp_q.pop_front());
    tick(); chk("ct_dack1", d_ack, 1); d_req = 0;
    tick(); tick(); chk("grant_order", bus.address, exp_q.pop_front());
    tick(); chk("ct_fack1", f_ack, 1);
    f_addr = 32'h1004; set_d(0, 2, 0, 32'h2004, 0);
    tick(); tick(); chk("grant_order", bus.address, exp_q.pop_front());
    tick(); chk("ct_fack2", f_ack, 1); f_req = 0;
    tick(); tick(); chk("grant_order", bus.address, exp_q.pop_front());
    tick(); chk("ct_dack2", d_ack, 1);
    f_req = 1; f_addr = 32'h1008; set_d(0, 2, 0, 32'h2008, 0);
    tick(); tick(); chk("grant_order", bus.address, exp_q.pop_front());
    tick(); chk("ct_dack3", d_ack, 1); d_req = 0;
    tick(); tick(); chk("grant_order", bus.address, exp_q.pop_front());
    tick(); chk("ct_fack3", f_ack, 1); f_req = 0;
    tick();
    chk("grant_q_empty", exp_q.size(), 0);

    // Timeout: waitrequest stuck high.
    bus.waitrequest = 1; f_req = 1; f_addr = 32'h300;
    tick(); chk("to_read", bus.read, 1);
    for (int i = 0; i < 3; i++) begin tick(); chk("to_hold", bus.read, 1); end
    tick(); chk("to_drop", bus.read, 0); chk("to_ack", f_ack, 1); chk("to_err", f_err, 1);
    f_req = 0; bus.waitrequest = 0; tick();

    // Reset while a read is stalled on the bus.
    bus.waitrequest = 1; f_req = 1; f_addr = 32'h400;
    tick(); chk("rb_read", bus.read, 1);
    tick();
    reset = 1;
    tick(); chk("rb_drop", bus.read, 0); chk("rb_busy", busy, 0); chk("rb_noack", f_ack, 0);
    f_req = 0; bus.waitrequest = 0;
    tick(); reset = 0;
    tick(); chk("rb_noack2", f_ack, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (f_ack) begin
        if ($urandom_range(0, 1) == 1) new_fetch(); else f_req = 0;
      end else if (!f_req && $urandom_range(0, 2) == 0) new_fetch();
      if (d_ack) begin
        if ($urandom_range(0, 1) == 1) new_data(); else d_req = 0;
      end else if (!d_req && $urandom_range(0, 2) == 0) new_data();
      bus.waitrequest = ($urandom_range(0, 9) < 4);
      bus.readdata = $urandom();
      tick();
    end
    f_req = 0; d_req = 0; bus.waitrequest = 0;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
